// File: rtl/gpi_pkg.sv
// rtl/gpi_pkg.sv - shared GPI widths, defaults and counter sizing helper
package gpi_pkg;

  localparam int GPI_WIDTH            = 4;
  localparam int GPI_DEBOUNCE_DEFAULT = 100000;

  typedef logic [GPI_WIDTH-1:0] gpi_vec_t;

  // Counter width is max(1, clog2(cycles)); clog2 of 1 or 2 would give 0 or 1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gpi_debounce_if.sv
// rtl/gpi_debounce_if.sv - raw pad / debounced level bundle; IRQ signals under GPI_DEBOUNCE_IRQ_EN
interface gpi_debounce_if #(
  parameter int WIDTH = gpi_pkg::GPI_WIDTH
);

  logic [WIDTH-1:0] rawPort;
  logic [WIDTH-1:0] outPort;
  logic [WIDTH-1:0] risePulse;
  logic [WIDTH-1:0] fallPulse;

`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] irqClr;
  logic [WIDTH-1:0] irqPending;
  logic             irq;

  modport master (output rawPort, output irqClr,
                  input outPort, input risePulse, input fallPulse,
                  input irqPending, input irq);
  modport slave  (input rawPort, input irqClr,
                  output outPort, output risePulse, output fallPulse,
                  output irqPending, output irq);
`else
  modport master (output rawPort,
                  input outPort, input risePulse, input fallPulse);
  modport slave  (input rawPort,
                  output outPort, output risePulse, output fallPulse);
`endif

endinterface

// File: rtl/gpi_debounce_ch.sv
// rtl/gpi_debounce_ch.sv - one channel: 2-flop synchroniser, stability counter, edge pulses
module gpi_debounce_ch
  import gpi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      // Any return to the accepted level restarts the qualification window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - per-bit debounce ahead of GPI inPort; optional IRQ via GPI_DEBOUNCE_IRQ_EN
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int WIDTH           = GPI_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  gpi_debounce_if.slave  bus
);

  logic [WIDTH-1:0] level_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpi_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.rawPort[i]),
      .level(level_vec[i]),
      .rise (rise_vec[i]),
      .fall (fall_vec[i])
    );
  end

  assign bus.outPort   = level_vec;
  assign bus.risePulse = rise_vec;
  assign bus.fallPulse = fall_vec;

`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] pending_q;

  // Set is ORed in after the clear so a coincident rise keeps the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~bus.irqClr) | rise_vec;
    end
  end

  assign bus.irqPending = pending_q;
  assign bus.irq        = |pending_q;
`endif

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Input-conditioning stage directly upstream of the GPI peripheral.
- Takes raw, asynchronous, possibly bouncing board inputs (switches/buttons) and synchronises each bit into the clk domain.
- Debounces each bit with a per-channel stability counter, then drives the clean levels into the GPI peripheral's inPort.
- Also produces one-cycle rise/fall pulses per channel for later interrupt use.

Parameters:
- WIDTH, 4, number of input channels; matches the GPI inPort width.
- DEBOUNCE_CYCLES, 100000, consecutive clk cycles a new level must hold before it is accepted (1 ms at 100 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rawPort  input  WIDTH  asynchronous pad inputs.
- outPort  output  WIDTH  debounced stable levels; connects to GPI inPort.
- risePulse  output  WIDTH  one-cycle pulse when outPort[i] goes 0->1.
- fallPulse  output  WIDTH  one-cycle pulse when outPort[i] goes 1->0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: while reset is high at an edge, all of the following load 0:
  - sync1, sync2, stable (outPort), counters, risePulse, fallPulse.
- Synchroniser: per bit, two flops: sync1 <= rawPort[i]; sync2 <= sync1. No logic between the two flops.
- Counter: CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)), unsigned. At each edge, per channel:
  - sync2 == stable: cnt <= 0, no output change.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0, and the matching pulse (rise if sync2 = 1, else fall) is registered high for the next cycle.
  - sync2 != stable otherwise: cnt <= cnt + 1.
- Pulses: risePulse/fallPulse are registered and high for exactly one cycle, the same cycle outPort shows the new level. Both are never high together on one channel.
- Latency: for a clean step, count the first edge that samples the new rawPort level as edge 1. outPort changes after edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any excursion of sync2 lasting fewer than DEBOUNCE_CYCLES cycles returns cnt to 0 and leaves outPort unchanged.
- Counter bounds: cnt never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around path.
- Channel independence: channels are fully independent. Simultaneous transitions on several bits each follow the rules above in the same cycle.
- Reset mid-count: pending transitions are discarded. After reset release, a still-asserted raw input requires the full latency again.

Optional Feature:
- Macro: GPI_DEBOUNCE_IRQ_EN.
- When defined, adds ports:
  - irqClr input WIDTH
  - irqPending output WIDTH
  - irq output 1
- irqPending[i] is sticky-set by risePulse[i] and cleared by irqClr[i]. If set and clear occur in the same cycle, set wins.
- irq = |irqPending, registered as a reduction of the pending flops (no extra cycle). Reset value 0.
- When undefined, these ports and flops do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package gpi_pkg holds:
  - localparam GPI_WIDTH = 4
  - localparam GPI_DEBOUNCE_DEFAULT = 100000
  - typedef logic [GPI_WIDTH-1:0] gpi_vec_t
- One sub-module, gpi_debounce_ch: single-bit synchroniser, counter and pulse logic.
- Top level: a generate loop over WIDTH, plus the optional IRQ register.

Test Plan (DEBOUNCE_CYCLES = 4, WIDTH = 4):
1. Reset held 3 cycles with rawPort = 4'hF -> outPort = 0, pulses 0. After release, outPort = 4'hF exactly 6 edges later, risePulse = 4'hF for one cycle.
2. rawPort[0] 0->1 held -> outPort[0] = 1 after edge 6, risePulse[0] high one cycle only. Then 1->0 held -> fallPulse[0] one cycle, outPort[0] = 0 after edge 6.
3. rawPort[1] high for 3 cycles, then low -> outPort[1] stays 0, no pulses.
4. rawPort[2] toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one risePulse[2], outPort[2] = 1 six edges after the final rise.
5. rawPort[3] rises, reset asserted 1 cycle at edge 4, rawPort held -> no pulse before reset. outPort[3] = 1 six edges after reset release.
6. (GPI_DEBOUNCE_IRQ_EN) rise on bit 0 -> irqPending = 4'h1, irq = 1. Assert irqClr[0] in the same cycle as a new risePulse[0] -> irqPending[0] stays 1. Clear alone -> irq = 0.
